// File: rtl/axi_framer_if.sv
// axi_framer_if: AXI-stream bundle (tvalid/tready/tdata/tuser/tlast) with master/slave views.
interface axi_framer_if #(
    parameter int DATA_WIDTH  = 32,
    parameter int TUSER_WIDTH = 8
);
    logic                   tvalid;
    logic                   tready;
    logic [DATA_WIDTH-1:0]  tdata;
    logic [TUSER_WIDTH-1:0] tuser;
    logic                   tlast;
    modport master (output tvalid, tdata, tuser, tlast, input tready);
    modport slave  (input tvalid, tdata, tuser, tlast, output tready);
endinterface

// File: rtl/axi_framer.sv
// axi_framer: segments an AXI stream into header-prefixed fixed-length frames.
// Define AXI_FRAMER_CKSUM_EN to append an XOR checksum word to every frame.
module axi_framer #(
    parameter int DATA_WIDTH  = 32,
    parameter int TUSER_WIDTH = 8,
    parameter int LEN_WIDTH   = 16
) (
    input  logic                 clk,
    input  logic                 async_reset_n,
    input  logic [LEN_WIDTH-1:0] pkt_len,
    axi_framer_if.slave          s_axis,
    axi_framer_if.master         m_axis,
    output logic [15:0]          seq_num
);
`ifdef AXI_FRAMER_CKSUM_EN
    typedef enum logic [1:0] {IDLE, PAY, TRL} state_t;
    logic [DATA_WIDTH-1:0] ck;
    logic                  trl_ld;
`else
    typedef enum logic [1:0] {IDLE, PAY} state_t;
`endif
    state_t                 state, state_nxt;
    logic [LEN_WIDTH-1:0]   cnt, len, eff_len;
    logic [TUSER_WIDTH-1:0] user_l;
    logic [15:0]            seq_q;
    logic                   m_valid, m_last;
    logic [DATA_WIDTH-1:0]  m_data;
    logic [TUSER_WIDTH-1:0] m_user;
    logic                   slot_free, hdr_ld, s_fire, close;

    assign slot_free      = ~m_valid | m_axis.tready;
    assign eff_len        = (pkt_len == '0) ? LEN_WIDTH'(1) : pkt_len;
    assign hdr_ld         = (state == IDLE) & s_axis.tvalid & slot_free;
    assign s_axis.tready  = (state == PAY) & slot_free;
    assign s_fire         = s_axis.tvalid & s_axis.tready;
    assign close          = (cnt + LEN_WIDTH'(1) == len) | s_axis.tlast;
    assign m_axis.tvalid  = m_valid;
    assign m_axis.tdata   = m_data;
    assign m_axis.tuser   = m_user;
    assign m_axis.tlast   = m_last;
    assign seq_num        = seq_q;
`ifdef AXI_FRAMER_CKSUM_EN
    assign trl_ld = (state == TRL) & slot_free;
`endif

    always_comb begin
        state_nxt = state;
        if (hdr_ld) state_nxt = PAY;
`ifdef AXI_FRAMER_CKSUM_EN
        if (s_fire && close) state_nxt = TRL;
        if (trl_ld) state_nxt = IDLE;
`else
        if (s_fire && close) state_nxt = IDLE;
`endif
    end

    always_ff @(posedge clk or negedge async_reset_n) begin
        if (!async_reset_n) begin
            state   <= IDLE;
            m_valid <= 1'b0;
            m_data  <= '0;
            m_user  <= '0;
            m_last  <= 1'b0;
            seq_q   <= '0;
            cnt     <= '0;
            len     <= '0;
            user_l  <= '0;
`ifdef AXI_FRAMER_CKSUM_EN
            ck      <= '0;
`endif
        end else begin
            state <= state_nxt;
`ifdef AXI_FRAMER_CKSUM_EN
            if (slot_free) m_valid <= hdr_ld | s_fire | trl_ld;
`else
            if (slot_free) m_valid <= hdr_ld | s_fire;
`endif
            // header reports the configured length even if tlast cuts the frame short
            if (hdr_ld) begin
                m_data <= DATA_WIDTH'({seq_q, 16'(eff_len)});
                m_user <= s_axis.tuser;
                m_last <= 1'b0;
                len    <= eff_len;
                user_l <= s_axis.tuser;
                cnt    <= '0;
                seq_q  <= seq_q + 16'd1;
`ifdef AXI_FRAMER_CKSUM_EN
                ck     <= '0;
`endif
            end
            if (s_fire) begin
                m_data <= s_axis.tdata;
                m_user <= user_l;
                cnt    <= cnt + LEN_WIDTH'(1);
`ifdef AXI_FRAMER_CKSUM_EN
                m_last <= 1'b0;
                ck     <= ck ^ s_axis.tdata;
`else
                m_last <= close;
`endif
            end
`ifdef AXI_FRAMER_CKSUM_EN
            if (trl_ld) begin
                m_data <= ck;
                m_user <= user_l;
                m_last <= 1'b1;
            end
`endif
        end
    end
endmodule

// File: tb/tb_axi_framer.sv
// tb_axi_framer: randomized bench for axi_framer against a frame-level queue model.
module tb_axi_framer;
    typedef struct packed {logic [31:0] d; logic [7:0] u; logic l;} word_t;
`ifdef AXI_FRAMER_CKSUM_EN
    localparam bit CK = 1'b1;
`else
    localparam bit CK = 1'b0;
`endif
    logic        clk = 1'b0;
    logic        async_reset_n = 1'b0;
    logic [15:0] pkt_len = 16'd0;
    logic [15:0] seq_num;
    logic [15:0] mseq = 16'd0;
    int          n_checks = 0, n_fail = 0;
    word_t       in_q[$], exp_q[$], obs_q[$];

    axi_framer_if #(.DATA_WIDTH(32), .TUSER_WIDTH(8)) s_if ();
    axi_framer_if #(.DATA_WIDTH(32), .TUSER_WIDTH(8)) m_if ();

    axi_framer #(.DATA_WIDTH(32), .TUSER_WIDTH(8), .LEN_WIDTH(16)) dut (
        .clk(clk), .async_reset_n(async_reset_n), .pkt_len(pkt_len),
        .s_axis(s_if), .m_axis(m_if), .seq_num(seq_num)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic add(input logic [31:0] d, input logic [7:0] u, input logic l);
        in_q.push_back('{d: d, u: u, l: l});
    endtask

    // expected output words for the queued input, one frame at a time
    function automatic void build(input int len_i);
        int eff = (len_i == 0) ? 1 : len_i;
        int i = 0;
        while (i < in_q.size()) begin
            logic [7:0]  u  = in_q[i].u;
            logic [31:0] ck = 32'd0;
            exp_q.push_back('{d: {mseq, 16'(eff)}, u: u, l: 1'b0});
            mseq++;
            for (int k = 0; k < eff && i < in_q.size(); k++) begin
                word_t s = in_q[i];
                bit last = (k == eff - 1) || s.l;
                i++;
                ck ^= s.d;
                exp_q.push_back('{d: s.d, u: u, l: last & !CK});
                if (last) break;
            end
            if (CK) exp_q.push_back('{d: ck, u: u, l: 1'b1});
        end
    endfunction

    task automatic run(input int len_i, input int ready_pct);
        int    limit;
        int    cyc = 0;
        bit    prev_stall = 0;
        word_t held = '0, cur;
        pkt_len = 16'(len_i);
        build(len_i);
        obs_q.delete();
        limit = 20 * exp_q.size() + 100;
        while (exp_q.size() > 0 && cyc < limit) begin
            @(negedge clk);
            m_if.tready = ($urandom_range(99) < ready_pct);
            s_if.tvalid = (in_q.size() > 0);
            if (in_q.size() > 0) begin
                s_if.tdata = in_q[0].d;
                s_if.tuser = in_q[0].u;
                s_if.tlast = in_q[0].l;
            end
            #1;
            cur = '{d: m_if.tdata, u: m_if.tuser, l: m_if.tlast};
            if (prev_stall) check("hold", {m_if.tvalid, cur}, {1'b1, held});
            if (m_if.tvalid && m_if.tready) begin
                check("out_word", cur, exp_q.pop_front());
                obs_q.push_back(cur);
            end
            prev_stall = m_if.tvalid && !m_if.tready;
            held = cur;
            if (s_if.tvalid && s_if.tready) void'(in_q.pop_front());
            cyc++;
        end
        check("timeout_left", exp_q.size(), 0);
        exp_q.delete();
        @(negedge clk);
        s_if.tvalid = 1'b0;
        m_if.tready = 1'b1;
        #1;
        check("input_drained", in_q.size(), 0);
        check("idle_valid", m_if.tvalid, 0);
        check("seq_num", seq_num, mseq);
    endtask

    initial begin
        int fw;
        s_if.tvalid = 1'b0; s_if.tdata = '0; s_if.tuser = '0; s_if.tlast = 1'b0;
        m_if.tready = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        check("rst_outputs", {m_if.tvalid, m_if.tdata, m_if.tuser, m_if.tlast}, 0);
        check("rst_seq", seq_num, 0);
        check("rst_sready", s_if.tready, 0);
        @(negedge clk);
        async_reset_n = 1'b1;

        // back-to-back, len 4
        for (int i = 1; i <= 8; i++) add(32'(i), 8'($urandom), 1'b0);
        run(4, 100);
        fw = 5 + int'(CK);
        check("t1_hdr0", obs_q[0].d, 32'h0000_0004);
        check("t1_hdr1", obs_q[fw].d, 32'h0001_0004);
        check("t1_p1", obs_q[1].d, 32'h1);
        check("t1_seq", seq_num, 16'd2);

        // early tlast on 2nd sample, then a full frame
        add(32'h11, 8'h5A, 1'b0); add(32'h22, 8'h01, 1'b1);
        for (int i = 0; i < 4; i++) add(32'h30 + 32'(i), 8'($urandom), 1'b0);
        run(4, 100);
        check("t2_hdr_len", obs_q[0].d[15:0], 16'd4);
        check("t2_user", obs_q[2].u, 8'h5A);
        if (!CK) check("t2_last", obs_q[2].l, 1);

        // random stalls, len 3
        for (int i = 0; i < 30; i++) add($urandom, 8'($urandom), ($urandom_range(9) == 0) || i == 29);
        run(3, 50);

        // len 0 treated as 1
        add(32'hAA, 8'h3C, 1'b0);
        run(0, 100);
        check("t4_hdr_len", obs_q[0].d[15:0], 16'd1);
        check("t4_pay", {obs_q[1].d, obs_q[1].l}, {32'hAA, !CK});

        // assorted lengths and backpressure
        for (int p = 0; p < 6; p++) begin
            for (int i = 0; i < 20; i++) add($urandom, 8'($urandom), ($urandom_range(7) == 0) || i == 19);
            run($urandom_range(5), 40 + 10 * p);
        end

        // sequence number wrap
        @(negedge clk);
        force dut.seq_q = 16'hFFFF;
        #1 release dut.seq_q;
        mseq = 16'hFFFF;
        add(32'h1, 8'h0, 1'b0); add(32'h2, 8'h0, 1'b0);
        run(1, 100);
        fw = 2 + int'(CK);
        check("wrap_hdr_ffff", obs_q[0].d[31:16], 16'hFFFF);
        check("wrap_hdr_0", obs_q[fw].d[31:16], 16'h0000);

`ifdef AXI_FRAMER_CKSUM_EN
        add(32'h0F, 8'h7, 1'b0); add(32'hF1, 8'h7, 1'b0);
        run(2, 100);
        check("cksum_word", {obs_q[3].d, obs_q[3].l}, {32'hFE, 1'b1});
`endif

        // async reset while a frame is stalled at the output
        @(negedge clk);
        pkt_len = 16'd4; m_if.tready = 1'b0;
        s_if.tvalid = 1'b1; s_if.tdata = 32'h55; s_if.tuser = 8'h9; s_if.tlast = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check("pre_rst_valid", m_if.tvalid, 1);
        async_reset_n = 1'b0;
        #1;
        check("mid_rst_outputs", {m_if.tvalid, m_if.tdata, m_if.tuser, m_if.tlast}, 0);
        check("mid_rst_seq", seq_num, 0);
        s_if.tvalid = 1'b0;
        @(negedge clk);
        async_reset_n = 1'b1;
        mseq = 16'd0;
        in_q.delete();
        add(32'h77, 8'h2, 1'b0); add(32'h78, 8'h2, 1'b1);
        run(4, 100);
        check("post_rst_hdr", obs_q[0].d, 32'h0000_0004);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
